sensor_scan_scheduler: RTL
==========================

Name: sensor_scan_scheduler

Overview:
Tick-driven scheduler that shares one measurement engine (e.g. ultrasonic/IR front end) among NUM_CH sensor channels. On each periodic tick from the pulse generator it runs one round-robin scan over the enabled channels. Per channel it issues a start, waits for done or timeout, then publishes per-round ok/timeout masks to the counting logic.

Parameters:
NUM_CH, 4, number of sensor channels sharing the engine (2..8)
CH_W, 2, width of channel select, = clog2(NUM_CH)
TIMEOUT_CYCLES, 1_500_000, max WAIT cycles per channel (30 ms at 50 MHz)
OVR_W, 8, width of saturating overrun counter

Ports:
clk  in  1  clock
rst  in  1  reset
tick  in  1  one-cycle scan request from the periodic pulse generator
enable  in  1  scan enable, sampled only in IDLE
ch_mask  in  NUM_CH  enabled channels, latched at round start
start  out  1  one-cycle start pulse to the shared engine
sel  out  CH_W  channel currently owning the engine
done  in  1  one-cycle completion pulse from the engine
abort  out  1  one-cycle pulse on timeout; engine must return to idle
busy  out  1  high in every state except IDLE
round_done  out  1  one-cycle pulse when a round's results are published
ok_mask  out  NUM_CH  channels that returned done in the last round
to_mask  out  NUM_CH  channels that timed out in the last round
overrun_cnt  out  OVR_W  ticks dropped because a round was in progress (saturating)

Behaviour:
- Reset is synchronous and active-high on rst, clock clk. Reset forces state IDLE. It clears to 0: start, sel, abort, busy, round_done, ok_mask, to_mask, overrun_cnt, the internal timer and the working masks. Reset mid-round aborts silently: no abort pulse, no publish.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, NEXT, PUBLISH.
- IDLE: on tick && enable && ch_mask != 0:
  - latch ch_mask to act_mask; clear working ok/to masks;
  - sel = lowest set bit of ch_mask; go to ISSUE.
  - tick with enable=0 or ch_mask=0 is ignored; no count, no round_done.
- ISSUE: start=1 for exactly this cycle; timer cleared; go to WAIT. Latency: tick at cycle t gives start high at t+1.
- WAIT: timer increments each cycle.
  - done=1: set working ok bit[sel]; go to NEXT.
  - Otherwise, if timer == TIMEOUT_CYCLES-1: set working to bit[sel]; abort=1 next cycle (in NEXT); go to NEXT.
  - done and timeout in the same cycle: done wins, no abort.
- NEXT: find the next set bit of act_mask with index > sel.
  - Found: update sel; go to ISSUE (no idle gap beyond this cycle).
  - None: go to PUBLISH.
- PUBLISH: copy working masks to ok_mask/to_mask; round_done=1 for this cycle; go to IDLE.
- ok_mask/to_mask are stable between publishes. ok_mask & to_mask == 0 always.
- done outside WAIT is ignored.
- tick in any non-IDLE state, including PUBLISH: dropped; overrun_cnt += 1, saturating at 2^OVR_W-1. overrun_cnt clears only on reset.
- enable or ch_mask change mid-round has no effect until the next IDLE.
- Timer is 32-bit unsigned. TIMEOUT_CYCLES must be >= 2.
- Round cycle count with k enabled channels, all answering after d cycles of WAIT: k*(d+2)+1 cycles from tick to round_done.

Decomposition:
- Shared package smartcount_pkg: FSM state encoding, default TIMEOUT_CYCLES, and OVR_W.
- One sub-module, next_ch_finder. It is combinational: given mask, current index and a "from start" flag, it returns the next set index and a found flag. It is used both in IDLE (lowest bit) and in NEXT.

Test Plan:
1. Bench with TIMEOUT_CYCLES=20, ch_mask=4'b1011, done returned 3 cycles after each start -> start asserted with sel=0, then 1, then 3. round_done asserted, ok_mask=1011, to_mask=0000.
2. ch_mask=4'b0110, no done on ch2 -> ch2 WAIT lasts exactly 20 cycles, then abort=1 for one cycle. Published ok_mask=0010, to_mask=0100.
3. done asserted on the exact cycle timer=19 -> counted ok, abort stays 0.
4. Three ticks during one round -> overrun_cnt=3 and the round completes normally. Force 300 overruns -> overrun_cnt=255.
5. tick with enable=0 and tick with ch_mask=0 -> no start, busy stays 0, overrun_cnt unchanged.
6. rst asserted while in WAIT -> next cycle all outputs 0, state IDLE. A following tick starts a fresh round from the lowest enabled channel.

Source files
------------

// File: rtl/smartcount_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | smartcount_pkg                                                     |
// | Shared constants and FSM encoding for the sensor scan scheduler.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package smartcount_pkg;

    localparam int c_TIMEOUT_CYCLES = 1_500_000;
    localparam int c_OVR_W          = 8;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ISSUE   = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_NEXT    = 3'd3;
    localparam logic [2:0] c_ST_PUBLISH = 3'd4;

endpackage
`default_nettype wire

// File: rtl/next_ch_finder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | next_ch_finder                                                     |
// | Returns the next set mask bit above cur, or the lowest set bit.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module next_ch_finder #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              from_start,
    output logic [CH_W-1:0]   next_idx,
    output logic              found
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                next_idx = CH_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sensor_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sensor_scan_scheduler                                              |
// | Tick-driven round-robin scan of sensor channels on one engine.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sensor_scan_scheduler
    import smartcount_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
    parameter int OVR_W          = c_OVR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              start,
    output logic [CH_W-1:0]   sel,
    input  logic              done,
    output logic              abort,
    output logic              busy,
    output logic              round_done,
    output logic [NUM_CH-1:0] ok_mask,
    output logic [NUM_CH-1:0] to_mask,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam logic [31:0] c_TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]        r_state;
    logic [CH_W-1:0]   r_sel;
    logic              r_start;
    logic              r_abort;
    logic              r_busy;
    logic              r_round_done;
    logic [NUM_CH-1:0] r_act_mask;
    logic [NUM_CH-1:0] r_wrk_ok;
    logic [NUM_CH-1:0] r_wrk_to;
    logic [NUM_CH-1:0] r_ok_mask;
    logic [NUM_CH-1:0] r_to_mask;
    logic [OVR_W-1:0]  r_overrun;
    logic [31:0]       r_timer;

    logic [NUM_CH-1:0] w_find_mask;
    logic              w_from_start;
    logic [CH_W-1:0]   w_next_ch;
    logic              w_found;
    logic              w_timeout;

    // One finder serves both round start (lowest bit of the live mask)
    // and channel advance (next bit of the latched mask).
    assign w_from_start = (r_state == c_ST_IDLE);
    assign w_find_mask  = w_from_start ? ch_mask : r_act_mask;
    assign w_timeout    = (r_timer == c_TIMER_LAST);

    next_ch_finder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_finder (
        .mask       (w_find_mask),
        .cur        (r_sel),
        .from_start (w_from_start),
        .next_idx   (w_next_ch),
        .found      (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_sel        <= '0;
            r_start      <= 1'b0;
            r_abort      <= 1'b0;
            r_busy       <= 1'b0;
            r_round_done <= 1'b0;
            r_act_mask   <= '0;
            r_wrk_ok     <= '0;
            r_wrk_to     <= '0;
            r_ok_mask    <= '0;
            r_to_mask    <= '0;
            r_overrun    <= '0;
            r_timer      <= '0;
        end else begin
            r_start      <= 1'b0;
            r_abort      <= 1'b0;
            r_round_done <= 1'b0;

            if (tick && (r_state != c_ST_IDLE) && (r_overrun != '1)) begin
                r_overrun <= r_overrun + 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (tick && enable && w_found) begin
                        r_act_mask <= ch_mask;
                        r_wrk_ok   <= '0;
                        r_wrk_to   <= '0;
                        r_sel      <= w_next_ch;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_timer <= r_timer + 32'd1;
                    // done has priority over a coincident timeout
                    if (done) begin
                        r_wrk_ok[r_sel] <= 1'b1;
                        r_state         <= c_ST_NEXT;
                    end else if (w_timeout) begin
                        r_wrk_to[r_sel] <= 1'b1;
                        r_abort         <= 1'b1;
                        r_state         <= c_ST_NEXT;
                    end
                end
                c_ST_NEXT: begin
                    if (w_found) begin
                        r_sel   <= w_next_ch;
                        r_start <= 1'b1;
                        r_state <= c_ST_ISSUE;
                    end else begin
                        r_ok_mask    <= r_wrk_ok;
                        r_to_mask    <= r_wrk_to;
                        r_round_done <= 1'b1;
                        r_state      <= c_ST_PUBLISH;
                    end
                end
                c_ST_PUBLISH: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign start       = r_start;
    assign sel         = r_sel;
    assign abort       = r_abort;
    assign busy        = r_busy;
    assign round_done  = r_round_done;
    assign ok_mask     = r_ok_mask;
    assign to_mask     = r_to_mask;
    assign overrun_cnt = r_overrun;

endmodule
`default_nettype wire
